// File: rtl/dmem_io_bus_if.sv
// Load/store request and response bus between a CPU load/store stage and dmem_io_bus.
// One-cycle request/acknowledge: ack, rdata and err are valid the cycle after req.
interface dmem_io_bus_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, size, addr, wdata,
    input  ack, rdata, err
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output ack, rdata, err
  );
endinterface

// File: rtl/dmem_io_bus.sv
// Data RAM with byte lanes plus memory-mapped output registers and synchronised inputs; 1-cycle ack.
// Define DMEM_IO_IRQ_EN to add the irq output and the irq_mask register at I/O index 14.
module dmem_io_bus #(
  parameter int DEPTH_WORDS = 32,
  parameter int NUM_OUT     = 2,
  parameter int NUM_IN      = 2,
  parameter int IO_BIT      = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  dmem_io_bus_if.slave          bus,
  output logic [32*NUM_OUT-1:0] out_port,
  input  logic [32*NUM_IN-1:0]  in_port,
  output logic [NUM_IN-1:0]     chg_flags
`ifdef DMEM_IO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] out_r [NUM_OUT];
  logic [31:0] sync1 [NUM_IN];
  logic [31:0] sync2 [NUM_IN];
  logic [31:0] prev  [NUM_IN];

  logic          io_sel;
  logic [3:0]    reg_idx;
  logic [AW-1:0] word_idx;
  logic          misaligned;
  logic [3:0]    lane_en;
  logic [31:0]   wdata_rep;
  logic          acc_ok;
  logic          ram_we;
  logic          io_we;
  logic [31:0]   rd_word;
  logic [NUM_IN-1:0] chg_set;
  logic [NUM_IN-1:0] chg_clr;

  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

`ifdef DMEM_IO_IRQ_EN
  logic [NUM_IN-1:0] irq_mask;
`endif

  // Upper address bits beyond the decoded fields are intentionally ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^bus.addr;

  assign io_sel   = bus.addr[IO_BIT];
  assign reg_idx  = bus.addr[5:2];
  assign word_idx = bus.addr[AW+1:2];

  always_comb begin
    misaligned = 1'b0;
    lane_en    = 4'b1111;
    wdata_rep  = bus.wdata;
    case (bus.size)
      2'd0: begin
        lane_en   = 4'b0001 << bus.addr[1:0];
        wdata_rep = {4{bus.wdata[7:0]}};
      end
      2'd1: begin
        misaligned = bus.addr[0];
        lane_en    = bus.addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{bus.wdata[15:0]}};
      end
      2'd2: misaligned = (bus.addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  assign acc_ok = bus.req && !misaligned;
  assign ram_we = acc_ok && bus.we && !io_sel;
  assign io_we  = acc_ok && bus.we && io_sel;

  always_comb begin
    for (int k = 0; k < NUM_IN; k++) begin
      chg_set[k] = (sync2[k] != prev[k]);
    end
    chg_clr = (io_we && reg_idx == 4'd15) ? bus.wdata[NUM_IN-1:0] : '0;
  end

  always_comb begin
    rd_word = '0;
    if (!io_sel) begin
      rd_word = mem[word_idx];
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (reg_idx == 4'(k)) rd_word = out_r[k];
      end
      for (int k = 0; k < NUM_IN; k++) begin
        if (reg_idx == 4'(8 + k)) rd_word = sync2[k];
      end
      if (reg_idx == 4'd15) rd_word = 32'(chg_flags);
`ifdef DMEM_IO_IRQ_EN
      if (reg_idx == 4'd14) rd_word = 32'(irq_mask);
`endif
    end
  end

  // RAM has no reset: contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (!reset && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      chg_flags <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_r[k] <= '0;
      for (int k = 0; k < NUM_IN; k++) begin
        sync1[k] <= '0;
        sync2[k] <= '0;
        prev[k]  <= '0;
      end
`ifdef DMEM_IO_IRQ_EN
      irq_mask <= '0;
      irq      <= 1'b0;
`endif
    end else begin
      ack_q   <= bus.req;
      err_q   <= bus.req && misaligned;
      rdata_q <= (acc_ok && !bus.we) ? rd_word : '0;
      for (int k = 0; k < NUM_IN; k++) begin
        sync1[k] <= in_port[32*k +: 32];
        sync2[k] <= sync1[k];
        prev[k]  <= sync2[k];
      end
      // A fresh change wins over a write-1-to-clear in the same cycle.
      chg_flags <= (chg_flags & ~chg_clr) | chg_set;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (io_we && reg_idx == 4'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) out_r[k][8*b +: 8] <= wdata_rep[8*b +: 8];
          end
        end
      end
`ifdef DMEM_IO_IRQ_EN
      if (io_we && reg_idx == 4'd14) irq_mask <= bus.wdata[NUM_IN-1:0];
      irq <= |(chg_flags & irq_mask);
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      out_port[32*k +: 32] = out_r[k];
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule
